lsu_dmem_master: RTL and testbench

Load/store unit that initiates all data-memory traffic from the pipeline's MEM stage. It accepts one RISC-V load or store per request (LB/LH/LW/LD/LBU/LHU/LWU/SB/SH/SW/SD) and drives the 64-bit doubleword port of `data_mem` (`mem_rd`, `mem_wr`, `add`, `in`, `out`). Sub-doubleword stores become read-modify-write sequences. The unit returns sign- or zero-extended load data or an error response.

---
 rtl/lsu_dmem_master.sv | 129 ++++++++++++
 tb/tb_lsu_dmem_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: load/store unit driving a 64-bit big-endian doubleword data memory
module lsu_dmem_master #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    state_t      state_q, state_d;
    logic        we_q, we_d, err_q, err_d;
    logic [2:0]  f3_q, f3_d, o_q, o_d;
    logic [63:0] base_q, base_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic        accept, req_err;
    logic [3:0]  req_bytes;
    logic [64:0] req_end;
    logic [63:0] req_base;
    logic [6:0]  nbits, sa;
    logic [5:0]  ob;
    logic [63:0] sh, ext, mask, ins, merged;
    logic signed [63:0] ext_s;

    // Classify the incoming request: size, legality, bounds (65-bit so it cannot wrap) and window base
    always_comb begin
        req_bytes = 4'd1 << req_funct3[1:0];
        req_end   = {1'b0, req_addr} + {61'd0, req_bytes} - 65'd1;
        req_err   = (req_we ? req_funct3[2] : (req_funct3 == 3'b111)) || (req_end > 65'(MEM_BYTES - 1));
        req_base  = (req_addr > 64'(MEM_BYTES - 8)) ? 64'(MEM_BYTES - 8) : req_addr;
        accept    = req_valid && req_ready;
    end

    // Field extraction and store merge inside the big-endian window; field sits at bits [63-8o -: 8s]
    always_comb begin
        nbits  = 7'd8 << f3_q[1:0];
        sa     = 7'd64 - nbits;
        ob     = {o_q, 3'b000};
        sh     = mem_rdata << ob;
        ext_s  = $signed(sh) >>> sa;
        ext    = f3_q[2] ? (sh >> sa) : ext_s;
        mask   = ({64{1'b1}} << sa) >> ob;
        ins    = (wdata_q << sa) >> ob;
        merged = (mem_rdata & ~mask) | (ins & mask);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: errors go straight to RESP, SD skips the read, everything else reads first
    always_comb begin
        state_d = (state_q == IDLE) ? (!accept ? IDLE :
                                       req_err ? RESP :
                                       (req_we && req_funct3[1:0] == 2'b11) ? WR : RD) :
                  (state_q == RD)   ? (we_q ? WR : RESP) :
                  (state_q == WR)   ? RESP : IDLE;
    end

    // Outputs decode from state; data outputs are zero outside the cycles that use them
    always_comb begin
        req_ready  = rst_n && (state_q == IDLE);
        mem_rd     = (state_q == RD);
        mem_wr     = (state_q == WR);
        mem_addr   = (mem_rd || mem_wr) ? base_q : 64'd0;
        mem_wdata  = mem_wr ? wdata_q : 64'd0;
        resp_valid = (state_q == RESP);
        resp_rdata = resp_valid ? rdata_q : 64'd0;
        resp_err   = resp_valid && err_q;
    end

    // Datapath next-state: capture request on accept, then the read result or merged doubleword in RD
    always_comb begin
        we_d    = we_q;
        f3_d    = f3_q;
        base_d  = base_q;
        o_d     = o_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            we_d    = req_we;
            f3_d    = req_funct3;
            base_d  = req_base;
            o_d     = req_addr[2:0] - req_base[2:0];
            wdata_d = req_wdata;
            rdata_d = 64'd0;
            err_d   = req_err;
        end
        if (state_q == RD) begin
            wdata_d = we_q ? merged : wdata_q;
            rdata_d = we_q ? rdata_q : ext;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            base_q  <= 64'd0;
            o_q     <= 3'd0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            f3_q    <= f3_d;
            base_q  <= base_d;
            o_q     <= o_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb_lsu_dmem_master: randomized and directed checks of lsu_dmem_master against a byte-array model
module tb_lsu_dmem_master;
    typedef struct packed {
        logic        ready;
        logic        rd;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        rv;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_rd, mem_wr;
    logic [63:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  snap [256];
    logic        sync_mem = 1'b0;
    exp_t        q [$];
    int          nvec = 0, nerr = 0, n_rd = 0, n_wr = 0, n_rv = 0;
    logic [63:0] last_rdata, last_addr, last_wdata;
    logic        last_err;

    always #5 clk = ~clk;

    lsu_dmem_master #(.MEM_BYTES(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Data memory: combinational big-endian read, write committed at the negedge
    always_comb begin
        mem_rdata = 64'd0;
        if (mem_addr <= 64'd248)
            for (int k = 0; k < 8; k++) mem_rdata[63-8*k -: 8] = mem[mem_addr[7:0] + 8'(k)];
    end

    always @(negedge clk) begin
        if (sync_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        end else if (mem_wr && mem_addr <= 64'd248) begin
            for (int k = 0; k < 8; k++) mem[mem_addr[7:0] + 8'(k)] <= mem_wdata[63-8*k -: 8];
        end
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h (t=%0t)", n, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the next predicted cycle, or the idle picture if nothing is pending
    task automatic check_cycle();
        exp_t e;
        if (q.size() > 0) e = q.pop_front();
        else begin
            e = '0;
            e.ready = rst_n;
        end
        chk("req_ready", 64'(req_ready), 64'(e.ready));
        chk("mem_rd", 64'(mem_rd), 64'(e.rd));
        chk("mem_wr", 64'(mem_wr), 64'(e.wr));
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_wdata", mem_wdata, e.wdata);
        chk("resp_valid", 64'(resp_valid), 64'(e.rv));
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 64'(resp_err), 64'(e.err));
        if (resp_valid) begin
            n_rv++;
            last_rdata = resp_rdata;
            last_err   = resp_err;
        end
        if (mem_rd) begin
            n_rd++;
            last_addr = mem_addr;
        end
        if (mem_wr) begin
            n_wr++;
            last_addr  = mem_addr;
            last_wdata = mem_wdata;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_cycle();
    endtask

    // Reference: cycle-by-cycle outputs after accept, derived from byte-level memory semantics
    task automatic predict(input logic we, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        exp_t r;
        logic [63:0] v;
        int s, b, ai;
        s = 1 << f3[1:0];
        r = '0;
        if ((we ? f3[2] : (f3 == 3'b111)) || a > 64'(256 - s)) begin
            r.rv  = 1'b1;
            r.err = 1'b1;
            q.push_back(r);
            return;
        end
        ai = int'(a);
        b  = (ai > 248) ? 248 : ai;
        if (!we) begin
            v = 64'd0;
            for (int k = 0; k < s; k++) v = (v << 8) | 64'(ref_mem[ai + k]);
            if (!f3[2] && s < 8 && v[8*s-1]) v = v | (~64'd0 << (8 * s));
            r.rd = 1'b1; r.addr = 64'(b);
            q.push_back(r);
            r = '0; r.rv = 1'b1; r.rdata = v;
            q.push_back(r);
        end else begin
            for (int k = 0; k < s; k++) ref_mem[ai + k] = 8'(wd >> (8 * (s - 1 - k)));
            v = 64'd0;
            for (int k = 0; k < 8; k++) v = (v << 8) | 64'(ref_mem[b + k]);
            if (s < 8) begin
                r.rd = 1'b1; r.addr = 64'(b);
                q.push_back(r);
                r = '0;
            end
            r.wr = 1'b1; r.addr = 64'(b); r.wdata = v;
            q.push_back(r);
            r = '0; r.rv = 1'b1;
            q.push_back(r);
        end
    endtask

    task automatic junk();
        req_valid  = 1'($urandom_range(0, 1));
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom);
        req_addr   = {$urandom, $urandom};
        req_wdata  = {$urandom, $urandom};
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        n_rd = 0; n_wr = 0; n_rv = 0;
        last_rdata = 'x; last_err = 1'bx; last_addr = 'x; last_wdata = 'x;
        predict(we, f3, a, wd);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        tick();
        for (int c = 0; c < 8 && q.size() > 0; c++) begin
            junk();
            tick();
        end
        chk("drain", 64'(q.size()), 64'd0);
        q.delete();
        junk();
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 64'd0; req_wdata = 64'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i + 1);
        ref_mem[254] = 8'h7F;
        ref_mem[255] = 8'h80;
        sync_mem = 1'b1;
        tick();
        tick();
        sync_mem = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        do_req(1'b0, 3'b011, 64'd0, 64'd0);
        chk("LD0_data", last_rdata, 64'h0102030405060708);
        chk("LD0_addr", last_addr, 64'd0);
        chk("LD0_err", 64'(last_err), 64'd0);
        do_req(1'b0, 3'b000, 64'd255, 64'd0);
        chk("LB255_data", last_rdata, 64'hFFFFFFFFFFFFFF80);
        chk("LB255_addr", last_addr, 64'd248);
        do_req(1'b0, 3'b100, 64'd255, 64'd0);
        chk("LBU255_data", last_rdata, 64'h0000000000000080);
        do_req(1'b0, 3'b001, 64'd254, 64'd0);
        chk("LH254_data", last_rdata, 64'h0000000000007F80);
        do_req(1'b1, 3'b000, 64'd2, 64'hAB);
        chk("SB2_wdata", last_wdata, 64'hAB0405060708090A);
        chk("SB2_addr", last_addr, 64'd2);
        chk("SB2_strobes", 64'(n_rd * 10 + n_wr), 64'd11);
        do_req(1'b0, 3'b011, 64'd0, 64'd0);
        chk("LD0_after_SB", last_rdata, 64'h0102AB0405060708);
        do_req(1'b1, 3'b011, 64'd250, 64'h1122334455667788);
        chk("SD250_err", 64'(last_err), 64'd1);
        chk("SD250_strobes", 64'(n_rd + n_wr), 64'd0);
        do_req(1'b0, 3'b010, 64'd253, 64'd0);
        chk("LW253_err", 64'(last_err), 64'd1);
        do_req(1'b0, 3'b010, 64'd252, 64'd0);
        chk("LW252_err", 64'(last_err), 64'd0);
        do_req(1'b0, 3'b111, 64'd0, 64'd0);
        chk("LD111_err", 64'(last_err), 64'd1);
        do_req(1'b1, 3'b100, 64'd0, 64'hFF);
        chk("ST100_err", 64'(last_err), 64'd1);
        chk("ST100_strobes", 64'(n_rd + n_wr), 64'd0);

        snap = ref_mem;
        n_rd = 0; n_wr = 0; n_rv = 0;
        predict(1'b1, 3'b010, 64'd8, 64'hDEADBEEF);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 64'd8; req_wdata = 64'hDEADBEEF;
        tick();
        rst_n = 1'b0;
        req_valid = 1'b0;
        q.delete();
        tick();
        rst_n = 1'b1;
        ref_mem = snap;
        tick();
        tick();
        chk("abort_wr", 64'(n_wr), 64'd0);
        chk("abort_resp", 64'(n_rv), 64'd0);
        chk("abort_mem", {32'd0, mem[8], mem[9], mem[10], mem[11]}, 64'h090A0B0C);

        repeat (400) begin
            logic [63:0] a;
            case ($urandom_range(0, 9))
                0:       a = {$urandom, $urandom};
                1:       a = 64'd256 - 64'($urandom_range(0, 9));
                default: a = 64'($urandom_range(0, 263));
            endcase
            do_req(1'($urandom_range(0, 1)), 3'($urandom), a, {$urandom, $urandom});
        end

        req_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 256; i++) chk("mem_image", 64'(mem[i]), 64'(ref_mem[i]));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
